// File: rtl/clk_div_nco.sv
// clk_div_nco
//   Multi-channel fractional clock divider built from one phase accumulator
//   per channel. Each rising edge an enabled channel adds its programmable
//   increment to its accumulator, modulo 2^ACC_W. The output frequency is
//   f_clk * inc / 2^ACC_W.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   reset     asynchronous, active-high reset
//   en        per-channel accumulate enable
//   sync_clr  synchronous clear of every accumulator (phase alignment)
//   inc_wr    one-cycle increment write strobe
//   inc_sel   channel index for the write; indices >= NUM_CH are ignored
//   inc_data  new increment value
//   clk_out   per-channel divided clock (accumulator MSB, ~50% duty)
//   tick      per-channel registered one-cycle pulse on accumulator wrap
//   inc_q     current increments, channel i at [i*ACC_W +: ACC_W]
module clk_div_nco #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 26,
    parameter int DEFAULT_INC = 160,
    parameter int CH_W        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         en,
    input  logic                      sync_clr,
    input  logic                      inc_wr,
    input  logic [CH_W-1:0]           inc_sel,
    input  logic [ACC_W-1:0]          inc_data,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH*ACC_W-1:0]   inc_q
);

    localparam logic [ACC_W-1:0] DEF_INC = ACC_W'(DEFAULT_INC);

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [ACC_W-1:0]  inc [NUM_CH];
    logic [NUM_CH-1:0] tick_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                inc[i] <= DEF_INC;
            end
            tick_r <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync_clr) begin
                    acc[i]    <= '0;
                    tick_r[i] <= 1'b0;
                end else if (en[i]) begin
                    // Carry out of the ACC_W+1 bit sum is the wrap strobe.
                    {tick_r[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, inc[i]};
                end else begin
                    tick_r[i] <= 1'b0;
                end

                // Matching only existing channel indices drops out-of-range
                // writes. The add above sees the old increment this edge.
                if (inc_wr && (inc_sel == CH_W'(i))) begin
                    inc[i] <= inc_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign clk_out[g]                = acc[g][ACC_W-1];
        assign inc_q[g*ACC_W +: ACC_W]   = inc[g];
    end

    assign tick = tick_r;

endmodule
